// File: rtl/ddr4_app_responder.sv
// Stand-in for the MIG DDR4 user interface: emulated calibration, periodic command/write-data
// backpressure, a small word memory and fixed-latency in-order read return.
module ddr4_app_responder #(
  parameter int ADDR_WIDTH       = 29,
  parameter int CMD_WIDTH        = 3,
  parameter int DATA_WIDTH       = 64,
  parameter int MEM_AW           = 10,
  parameter int RD_LATENCY       = 4,
  parameter int CALIB_CYCLES     = 16,
  parameter int CMD_STALL_PERIOD = 7,
  parameter int WDF_STALL_PERIOD = 5
) (
  input  logic                  ui_clk,
  input  logic                  rst_n,
  input  logic                  app_en,
  input  logic [CMD_WIDTH-1:0]  app_cmd,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  init_calib_complete,
  output logic                  app_rdy,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic [31:0]           wr_cmd_cnt,
  output logic [31:0]           rd_cmd_cnt,
  output logic [2:0]            err_flags
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam int CS_W  = (CMD_STALL_PERIOD > 1) ? $clog2(CMD_STALL_PERIOD) : 1;
  localparam int WS_W  = (WDF_STALL_PERIOD > 1) ? $clog2(WDF_STALL_PERIOD) : 1;

  logic [CAL_W-1:0]      calib_cnt_q, calib_cnt_d;
  logic                  calib_q, calib_d;
  logic [CS_W-1:0]       cmd_stall_q, cmd_stall_d;
  logic [WS_W-1:0]       wdf_stall_q, wdf_stall_d;
  logic                  app_rdy_q, app_rdy_d;
  logic                  app_wdf_rdy_q, app_wdf_rdy_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [2:0]            err_q, err_d;
  logic [RD_LATENCY-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rd_data_d [RD_LATENCY];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [MEM_AW-1:0]     idx;
  logic                  wr_cmd, rd_cmd, bad_cmd, beat, wr_accept;
  logic                  unused_addr_bits;

  // Column bits in steps of 8 plus the bank bit; the rest of the address aliases.
  assign idx              = {app_addr[MEM_AW+1:3], app_addr[0]};
  assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:MEM_AW+2], app_addr[2:1]};

  assign wr_cmd    = app_en && app_rdy_q && (app_cmd == CMD_WIDTH'(0));
  assign rd_cmd    = app_en && app_rdy_q && (app_cmd == CMD_WIDTH'(1));
  assign bad_cmd   = app_en && app_rdy_q && (app_cmd > CMD_WIDTH'(1));
  assign beat      = app_wdf_wren && app_wdf_rdy_q;
  assign wr_accept = wr_cmd && beat && app_wdf_end;

  always_comb begin
    calib_cnt_d = calib_cnt_q;
    if (!calib_q) begin
      calib_cnt_d = calib_cnt_q + CAL_W'(1);
    end
    calib_d = calib_q || (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1));

    cmd_stall_d = '0;
    if (calib_q && CMD_STALL_PERIOD > 1 && cmd_stall_q != CS_W'(CMD_STALL_PERIOD - 1)) begin
      cmd_stall_d = cmd_stall_q + CS_W'(1);
    end
    wdf_stall_d = '0;
    if (calib_q && WDF_STALL_PERIOD > 1 && wdf_stall_q != WS_W'(WDF_STALL_PERIOD - 1)) begin
      wdf_stall_d = wdf_stall_q + WS_W'(1);
    end

    // Ready flags are computed from next-state so the outputs stay purely registered.
    app_rdy_d     = calib_d && !(CMD_STALL_PERIOD != 0 &&
                                 cmd_stall_d == CS_W'(CMD_STALL_PERIOD - 1));
    app_wdf_rdy_d = calib_d && !(WDF_STALL_PERIOD != 0 &&
                                 wdf_stall_d == WS_W'(WDF_STALL_PERIOD - 1));

    wr_cnt_d = wr_cnt_q + (wr_accept ? 32'd1 : 32'd0);
    rd_cnt_d = rd_cnt_q + (rd_cmd ? 32'd1 : 32'd0);
    err_d    = err_q | {bad_cmd, beat && !wr_accept, wr_cmd && !wr_accept};

    rd_valid_d    = '0;
    rd_valid_d[0] = rd_cmd;
    rd_data_d[0]  = rd_cmd ? mem[idx] : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_valid_d[i] = rd_valid_q[i-1];
      rd_data_d[i]  = rd_data_q[i-1];
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q   <= '0;
      calib_q       <= 1'b0;
      cmd_stall_q   <= '0;
      wdf_stall_q   <= '0;
      app_rdy_q     <= 1'b0;
      app_wdf_rdy_q <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      err_q         <= '0;
      rd_valid_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      calib_cnt_q   <= calib_cnt_d;
      calib_q       <= calib_d;
      cmd_stall_q   <= cmd_stall_d;
      wdf_stall_q   <= wdf_stall_d;
      app_rdy_q     <= app_rdy_d;
      app_wdf_rdy_q <= app_wdf_rdy_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_data_q[i] <= rd_data_d[i];
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge ui_clk) begin
    if (wr_accept) begin
      mem[idx] <= app_wdf_data;
    end
  end

  assign init_calib_complete = calib_q;
  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = app_wdf_rdy_q;
  assign app_rd_data         = rd_data_q[RD_LATENCY-1];
  assign app_rd_data_valid   = rd_valid_q[RD_LATENCY-1];
  assign app_rd_data_end     = rd_valid_q[RD_LATENCY-1];
  assign wr_cmd_cnt          = wr_cnt_q;
  assign rd_cmd_cnt          = rd_cnt_q;
  assign err_flags           = err_q;

endmodule

// File: tb/tb_ddr4_app_responder.sv
// Self-checking bench for ddr4_app_responder: directed vector table plus multi-cycle
// sequences for calibration, error flags, reset during reads and a stalled burst.
module tb_ddr4_app_responder;

  localparam int LAT = 4;
  localparam int CAL = 16;

  logic        ui_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [28:0] app_addr;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic [63:0] app_wdf_data;
  logic        init_calib_complete;
  logic        app_rdy;
  logic        app_wdf_rdy;
  logic [63:0] app_rd_data;
  logic        app_rd_data_valid;
  logic        app_rd_data_end;
  logic [31:0] wr_cmd_cnt;
  logic [31:0] rd_cmd_cnt;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [28:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] exp_q[$];

  ddr4_app_responder #(
    .ADDR_WIDTH(29), .CMD_WIDTH(3), .DATA_WIDTH(64), .MEM_AW(10),
    .RD_LATENCY(LAT), .CALIB_CYCLES(CAL), .CMD_STALL_PERIOD(7), .WDF_STALL_PERIOD(5)
  ) dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt), .err_flags(err_flags)
  );

  always #5 ui_clk = ~ui_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    app_en       = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
  endtask

  task automatic waitReady(input bit need_wdf);
    int n = 0;
    while (!(app_rdy === 1'b1 && (!need_wdf || app_wdf_rdy === 1'b1)) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout got not-ready expected ready within 64 cycles");
    end
  endtask

  task automatic doWrite(input logic [28:0] addr, input logic [63:0] data);
    waitReady(1'b1);
    app_en       = 1'b1;
    app_cmd      = 3'd0;
    app_addr     = addr;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = data;
    step();
    driveIdle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_calib"}, 64'(init_calib_complete), 64'd0);
    checkOutput({tag, "_rdy"}, 64'(app_rdy), 64'd0);
    checkOutput({tag, "_wdf_rdy"}, 64'(app_wdf_rdy), 64'd0);
    checkOutput({tag, "_rd_data"}, app_rd_data, 64'd0);
    checkOutput({tag, "_valid"}, 64'(app_rd_data_valid), 64'd0);
    checkOutput({tag, "_end"}, 64'(app_rd_data_end), 64'd0);
    checkOutput({tag, "_wr_cnt"}, 64'(wr_cmd_cnt), 64'd0);
    checkOutput({tag, "_rd_cnt"}, 64'(rd_cmd_cnt), 64'd0);
    checkOutput({tag, "_err"}, 64'(err_flags), 64'd0);
  endtask

  // Reset must already be released between edges; edge n is the n-th edge afterwards.
  task automatic calibCheck();
    for (int n = 1; n <= CAL; n++) begin
      step();
      checkOutput("valid_during_calib", 64'(app_rd_data_valid), 64'd0);
      if (n == CAL - 1) begin
        checkOutput("calib_edge15", 64'(init_calib_complete), 64'd0);
        checkOutput("rdy_edge15", 64'(app_rdy), 64'd0);
        checkOutput("wdf_rdy_edge15", 64'(app_wdf_rdy), 64'd0);
      end
      if (n == CAL) begin
        checkOutput("calib_edge16", 64'(init_calib_complete), 64'd1);
        checkOutput("rdy_edge16", 64'(app_rdy), 64'd1);
        checkOutput("wdf_rdy_edge16", 64'(app_wdf_rdy), 64'd1);
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveIdle();
    repeat (3) step();
    checkResetValues("reset");
    rst_n = 1'b1;
    calibCheck();
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    if (!v.is_read) begin
      doWrite(v.addr, v.data);
    end else begin
      waitReady(1'b0);
      app_en   = 1'b1;
      app_cmd  = 3'd1;
      app_addr = v.addr;
      step();
      driveIdle();
      for (int i = 0; i <= LAT; i++) begin
        if (i > 0) step();
        if (i < LAT - 1) begin
          checkOutput($sformatf("vec%0d_valid_early_%0d", id, i), 64'(app_rd_data_valid), 64'd0);
        end else if (i == LAT - 1) begin
          checkOutput($sformatf("vec%0d_valid", id), 64'(app_rd_data_valid), 64'd1);
          checkOutput($sformatf("vec%0d_end", id), 64'(app_rd_data_end), 64'd1);
          checkOutput($sformatf("vec%0d_data", id), app_rd_data, v.data);
        end else begin
          checkOutput($sformatf("vec%0d_valid_late", id), 64'(app_rd_data_valid), 64'd0);
        end
      end
    end
  endtask

  function automatic logic [63:0] burstData(input int row, input int col);
    return {16'hC0DE, 8'(row), 8'(col), 8'(col), 8'(row), 16'h5A5A};
  endfunction

  initial begin
    int issued, got, cyc, wr_before, rd_before;

    vecs[0] = '{1'b0, 29'h08,   64'hA5A5_0000_0000_0001};
    vecs[1] = '{1'b1, 29'h08,   64'hA5A5_0000_0000_0001};
    vecs[2] = '{1'b0, 29'h09,   64'h5A5A_1234_5678_9ABC};
    vecs[3] = '{1'b1, 29'h09,   64'h5A5A_1234_5678_9ABC};
    vecs[4] = '{1'b1, 29'h08,   64'hA5A5_0000_0000_0001};
    vecs[5] = '{1'b1, 29'h0E,   64'hA5A5_0000_0000_0001};
    vecs[6] = '{1'b0, 29'h0A,   64'hDEAD_BEEF_0000_0002};
    vecs[7] = '{1'b1, 29'h08,   64'hDEAD_BEEF_0000_0002};
    vecs[8] = '{1'b1, 29'h09,   64'h5A5A_1234_5678_9ABC};
    vecs[9] = '{1'b1, 29'h1008, 64'hDEAD_BEEF_0000_0002};

    driveIdle();
    doReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end
    checkOutput("table_wr_cnt", 64'(wr_cmd_cnt), 64'd3);
    checkOutput("table_rd_cnt", 64'(rd_cmd_cnt), 64'd7);
    checkOutput("table_err", 64'(err_flags), 64'd0);

    // Error flags: write without data, orphan data, illegal command.
    wr_before = wr_cmd_cnt;
    rd_before = rd_cmd_cnt;
    waitReady(1'b0);
    app_en   = 1'b1;
    app_cmd  = 3'd0;
    app_addr = 29'h08;
    step();
    driveIdle();
    checkOutput("err_wr_no_data", 64'(err_flags), 64'd1);
    checkOutput("err_wr_cnt_hold", 64'(wr_cmd_cnt), 64'(wr_before));
    waitReady(1'b1);
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = 64'h1111_2222_3333_4444;
    step();
    driveIdle();
    checkOutput("err_orphan_data", 64'(err_flags), 64'd3);
    waitReady(1'b0);
    app_en  = 1'b1;
    app_cmd = 3'd3;
    step();
    driveIdle();
    checkOutput("err_illegal_cmd", 64'(err_flags), 64'd7);
    checkOutput("err_wr_cnt_final", 64'(wr_cmd_cnt), 64'(wr_before));
    checkOutput("err_rd_cnt_final", 64'(rd_cmd_cnt), 64'(rd_before));
    vecs[0] = '{1'b1, 29'h08, 64'hDEAD_BEEF_0000_0002};
    applyStimulus(vecs[0], 10);

    // Eight back-to-back reads, reset after two have returned.
    issued = 0;
    got    = 0;
    cyc    = 0;
    while (got < 2 && cyc < 100) begin
      if (issued < 8 && app_rdy === 1'b1) begin
        app_en   = 1'b1;
        app_cmd  = 3'd1;
        app_addr = 29'h09;
        issued++;
      end else begin
        driveIdle();
      end
      step();
      cyc++;
      if (app_rd_data_valid === 1'b1) got++;
    end
    driveIdle();
    checkOutput("mid_valid_count", 64'(got), 64'd2);
    checkOutput("mid_inflight", 64'(issued > got), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (3) begin
      step();
      checkOutput("midreset_valid_hold", 64'(app_rd_data_valid), 64'd0);
    end
    rst_n = 1'b1;
    calibCheck();

    // Stalled burst: 64 writes then 64 reads in column-major order.
    doReset();
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 8; col++) begin
        doWrite(29'(row * 64 + col * 8 + 1), burstData(row, col));
      end
    end
    issued = 0;
    got    = 0;
    cyc    = 0;
    while (got < 64 && cyc < 2000) begin
      if (issued < 64 && app_rdy === 1'b1) begin
        app_en   = 1'b1;
        app_cmd  = 3'd1;
        app_addr = 29'((issued % 8) * 64 + (issued / 8) * 8 + 1);
        exp_q.push_back(burstData(issued % 8, issued / 8));
        issued++;
      end else begin
        driveIdle();
      end
      step();
      cyc++;
      if (app_rd_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL burst_extra_valid got data %h expected no valid", app_rd_data);
        end else begin
          checkOutput($sformatf("burst_data_%0d", got), app_rd_data, exp_q.pop_front());
        end
        got++;
      end
    end
    driveIdle();
    checkOutput("burst_returned", 64'(got), 64'd64);
    checkOutput("burst_wr_cnt", 64'(wr_cmd_cnt), 64'd64);
    checkOutput("burst_rd_cnt", 64'(rd_cmd_cnt), 64'd64);
    checkOutput("burst_err", 64'(err_flags), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr4_app_responder.md
# ddr4_app_responder

Synthesizable responder for the MIG DDR4 user (app) interface, the target side of the interleaver/deinterleaver read-write controllers. It emulates calibration, command/write-data acceptance with programmable backpressure, a small word-addressed memory and fixed-latency in-order read return. It sits in place of the MIG IP in block-level benches and FPGA loopback builds, so the controllers can be exercised without a DDR4 device.

## Interface
- ADDR_WIDTH, 29, app_addr width
- CMD_WIDTH, 3, app_cmd width
- DATA_WIDTH, 64, app_wdf_data / app_rd_data width
- MEM_AW, 10, log2 of memory depth in words (min 2)
- RD_LATENCY, 4, cycles from read accept to data valid (min 1, max 16)
- CALIB_CYCLES, 16, cycles after reset before init_calib_complete (min 1)
- CMD_STALL_PERIOD, 7, app_rdy drops for 1 cycle every N cycles; 0 = never
- WDF_STALL_PERIOD, 5, app_wdf_rdy drops for 1 cycle every N cycles; 0 = never
- ui_clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- app_en  in  1  command valid
- app_cmd  in  CMD_WIDTH  0 = write, 1 = read, others illegal
- app_addr  in  ADDR_WIDTH  command address
- app_wdf_wren  in  1  write data valid
- app_wdf_end  in  1  last beat of write data
- app_wdf_data  in  DATA_WIDTH  write data
- init_calib_complete  out  1  calibration done, sticky
- app_rdy  out  1  command accepted this cycle if app_en
- app_wdf_rdy  out  1  write data accepted this cycle if app_wdf_wren
- app_rd_data  out  DATA_WIDTH  read data
- app_rd_data_valid  out  1  read data valid
- app_rd_data_end  out  1  equals app_rd_data_valid
- wr_cmd_cnt  out  32  accepted writes, wraps
- rd_cmd_cnt  out  32  accepted reads, wraps
- err_flags  out  3  sticky: [0] write without data, [1] orphan data, [2] illegal cmd

## Operation
- Calibration: counter runs from reset; init_calib_complete rises after CALIB_CYCLES edges, never falls until reset.
- Stall counters (one per stall parameter) free-run 0..N-1 only while calibrated, wrap to 0.
- app_rdy = calib && !(CMD_STALL_PERIOD!=0 && cmd_cnt==N-1); app_wdf_rdy analogous with its counter. Both 0 before calibration.
- Write accept: app_en && app_rdy && app_cmd==0 && app_wdf_wren && app_wdf_rdy && app_wdf_end; mem[idx] <= app_wdf_data; wr_cmd_cnt++.
- Write cmd with app_rdy but no accepted data beat in same cycle: not accepted as a write, err_flags[0] set, memory unchanged, command counts nothing. Data beat with app_wdf_rdy but no accepted write cmd: err_flags[1] set, data dropped.
- Read accept: app_en && app_rdy && app_cmd==1; mem[idx] sampled at the accept edge, pushed into a RD_LATENCY-deep valid/data shift pipeline; rd_cmd_cnt++.
- Illegal cmd (≠0,1) with app_en && app_rdy: dropped, err_flags[2] set.
- Address map: idx = {app_addr[MEM_AW+1:3], app_addr[0]} (column bits in steps of 8, bank bit 0); bits [2:1] and above MEM_AW+1 ignored, aliasing permitted.
- Reads return strictly in acceptance order; one read per cycle sustainable, no read-side backpressure.

## Timing
- Reset values: init_calib_complete 0, app_rdy 0, app_wdf_rdy 0, app_rd_data 0, app_rd_data_valid 0, app_rd_data_end 0, counters 0, err_flags 0, pipeline cleared; memory contents not reset.
- Read accepted at edge k → app_rd_data_valid high for exactly one cycle, sampled at edge k+RD_LATENCY.
- Write at edge k visible to a read accepted at edge k+1 or later. Write and read never coincide (one command per cycle).
- Reset mid-operation clears in-flight reads (no valid emitted), restarts calibration.
- app_rdy/app_wdf_rdy are registered outputs; no combinational path from inputs.

## Test plan
- Reset, CALIB_CYCLES=16 → init_calib_complete 0 through edge 15, 1 at edge 16; app_rdy low until then.
- Write 0xA5A5_0000_0000_0001 to addr 0x08, then read 0x08 → valid exactly RD_LATENCY=4 cycles after read accept, data matches; app_rd_data_end mirrors valid.
- Initiator-style burst of 64 writes (row 0..7, col 0..56 step 8, bank 1) then 64 reads in column-major order with CMD_STALL_PERIOD=7, WDF_STALL_PERIOD=5 → every returned word matches, wr_cmd_cnt=64, rd_cmd_cnt=64, err_flags=0.
- app_en, app_cmd=0 with app_wdf_wren=0 → err_flags=3'b001, wr_cmd_cnt unchanged; lone app_wdf_wren → err_flags[1] set; app_cmd=3 → err_flags[2] set.
- Back-to-back 8 reads, rst_n low after 2 data returned → no further valid, all outputs at reset values, calibration restarts.
- Addresses 0x08 bank0 and 0x09 bank1 written with different data → independent readback; addr 0x0E aliases 0x08.
